// File: rtl/core_seq_pkg.sv
// rtl/core_seq_pkg.sv - shared states, packing constants and job descriptor for core_seq_ctrl
package core_seq_pkg;

    localparam int CDATA_W     = 8;
    localparam int ONUM_W      = 8;
    localparam int GBUS_ADDR_W = 12;
    localparam int GBUS_DATA_W = 64;
    localparam int IDATA_W     = 8;

    // Quantized outputs packed into one core result word
    localparam int PACK      = GBUS_DATA_W / IDATA_W;
    localparam int PACK_LOG2 = $clog2(PACK);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_STREAM = 3'd1;
    localparam logic [2:0] ST_RRST   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef struct packed {
        logic [CDATA_W-1:0]     acc_num;
        logic [ONUM_W-1:0]      out_num;
        logic                   reuse;
        logic                   cmem_en;
        logic [GBUS_ADDR_W-1:0] cmem_base;
    } job_t;

endpackage

// File: rtl/core_seq_wb.sv
// rtl/core_seq_wb.sv - result word counter, cmem writeback address and drain watchdog (CORE_SEQ_TIMEOUT_EN)
module core_seq_wb
    import core_seq_pkg::*;
#(
    parameter int ONUM_BIT    = 8,
    parameter int GBUS_ADDR   = 12,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [GBUS_ADDR-1:0] load_base,
    input  logic                 cmem_en,
    input  logic                 count_en,
    input  logic                 in_drain,
    input  logic                 odata_valid,
    input  logic [ONUM_BIT-1:0]  exp_words,
    output logic [GBUS_ADDR-1:0] cmem_waddr,
    output logic                 words_done,
    output logic                 timeout
);

    logic [ONUM_BIT-1:0] word_cnt;
    logic                word_hit;

    assign word_hit = count_en && odata_valid;

    // Done when all words are in, including one counted this very cycle
    assign words_done = (word_cnt == exp_words) ||
                        (word_hit && ((word_cnt + 1'b1) == exp_words));

    // Count result words and step the writeback address when cmem is enabled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_cnt   <= '0;
            cmem_waddr <= '0;
        end else if (start) begin
            word_cnt   <= '0;
            cmem_waddr <= load_base;
        end else if (word_hit) begin
            word_cnt <= word_cnt + 1'b1;
            if (cmem_en) begin
                cmem_waddr <= cmem_waddr + 1'b1;
            end
        end
    end

`ifdef CORE_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;

    assign timeout = in_drain && !odata_valid && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Count consecutive word-less DRAIN cycles; any word restarts the count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt <= '0;
        end else if (start || !in_drain || odata_valid) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - job sequencer driving core buffer strobes; drain watchdog under CORE_SEQ_TIMEOUT_EN
module core_seq_ctrl
    import core_seq_pkg::*;
#(
    parameter int CDATA_BIT   = CDATA_W,
    parameter int ONUM_BIT    = ONUM_W,
    parameter int GBUS_ADDR   = GBUS_ADDR_W,
    parameter int GBUS_DATA   = GBUS_DATA_W,
    parameter int IDATA_BIT   = IDATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CDATA_BIT-1:0] cmd_acc_num,
    input  logic [ONUM_BIT-1:0]  cmd_out_num,
    input  logic                 cmd_abuf_reuse,
    input  logic                 cmd_cmem_en,
    input  logic [GBUS_ADDR-1:0] cmd_cmem_base,
    input  logic                 lbuf_empty,
    input  logic                 abuf_empty,
    input  logic                 abuf_reuse_empty,
    output logic                 lbuf_ren,
    output logic                 abuf_ren,
    output logic                 abuf_reuse_ren,
    output logic                 abuf_reuse_rst,
    output logic [CDATA_BIT-1:0] cfg_acc_num,
    input  logic                 core_odata_valid,
    output logic                 cmem_wen,
    output logic [GBUS_ADDR-1:0] cmem_waddr,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int PACK_T      = GBUS_DATA / IDATA_BIT;
    localparam int PACK_LOG2_T = $clog2(PACK_T);

    logic [2:0]           state;
    job_t                 job;
    logic [CDATA_BIT-1:0] beat_cnt;
    logic [ONUM_BIT-1:0]  out_cnt;
    logic                 err_q;

    logic start, cmd_bad, use_reuse, src_empty, beat, last_beat, last_pass;
    logic words_done, timeout;

    assign start   = (state == ST_IDLE) && cmd_valid;
    assign cmd_bad = (cmd_acc_num == '0) || (cmd_out_num == '0) ||
                     (cmd_out_num[PACK_LOG2_T-1:0] != '0);

    // Pass 0 always reads fresh activations; later passes use the reuse copy
    assign use_reuse = job.reuse && (out_cnt != '0);
    assign src_empty = use_reuse ? abuf_reuse_empty : abuf_empty;
    assign beat      = (state == ST_STREAM) && !lbuf_empty && !src_empty;
    assign last_beat = (beat_cnt == job.acc_num - 1'b1);
    assign last_pass = (out_cnt == job.out_num - 1'b1);

    assign lbuf_ren       = beat;
    assign abuf_ren       = beat && !use_reuse;
    assign abuf_reuse_ren = beat && use_reuse;
    assign abuf_reuse_rst = (state == ST_RRST);

    assign cmd_ready   = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign err         = err_q;
    assign cfg_acc_num = job.acc_num;
    assign cmem_wen    = busy && job.cmem_en;

    // Job FSM: latch command, sequence passes, wait for result words
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            job      <= '0;
            beat_cnt <= '0;
            out_cnt  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        job.acc_num   <= cmd_acc_num;
                        job.out_num   <= cmd_out_num;
                        job.reuse     <= cmd_abuf_reuse;
                        job.cmem_en   <= cmd_cmem_en;
                        job.cmem_base <= cmd_cmem_base;
                        beat_cnt      <= '0;
                        out_cnt       <= '0;
                        err_q         <= cmd_bad;
                        state         <= cmd_bad ? ST_DONE : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (beat) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            out_cnt  <= out_cnt + 1'b1;
                            if (last_pass) begin
                                state <= ST_DRAIN;
                            end else if (job.reuse) begin
                                state <= ST_RRST;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_RRST: state <= ST_STREAM;
                ST_DRAIN: begin
                    if (words_done) begin
                        state <= ST_DONE;
                    end else if (timeout) begin
                        state <= ST_DONE;
                        err_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    err_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    core_seq_wb #(
        .ONUM_BIT    (ONUM_BIT),
        .GBUS_ADDR   (GBUS_ADDR),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wb (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .load_base   (cmd_cmem_base),
        .cmem_en     (job.cmem_en),
        .count_en    ((state == ST_STREAM) || (state == ST_DRAIN)),
        .in_drain    (state == ST_DRAIN),
        .odata_valid (core_odata_valid),
        .exp_words   (job.out_num >> PACK_LOG2_T),
        .cmem_waddr  (cmem_waddr),
        .words_done  (words_done),
        .timeout     (timeout)
    );

endmodule
